// File: rtl/reg_bus_pkg.sv
// Shared types for the config-register bus: FSM states, request and
// response records, and the default address/data widths.
package reg_bus_pkg;

    localparam int REG_AW = 4;
    localparam int REG_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } reg_bus_state_e;

    typedef struct packed {
        logic              write;
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] wdata;
    } reg_bus_req_t;

    typedef struct packed {
        logic [REG_DW-1:0] rdata;
        logic              err;
    } reg_bus_rsp_t;

endpackage

// File: rtl/reg_bus_initiator.sv
// Register bus master: takes one request at a time, runs SETUP/ACCESS on
// the config-register bus with a bounded ack wait, returns data/status.
// TIMEOUT must be at least 2.
module reg_bus_initiator
    import reg_bus_pkg::*;
#(
    parameter int AW       = REG_AW,
    parameter int DW       = REG_DW,
    parameter int NUM_REGS = 8,
    parameter int TIMEOUT  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          bus_sel,
    output logic          bus_wr_en,
    output logic          bus_rd_en,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ack
);

    localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    reg_bus_state_e state_q, state_d;
    logic           write_q, write_d;
    logic [AW-1:0]  addr_q,  addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic           err_q,   err_d;

    // Next-state and capture logic for the transaction sequencer
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    if (32'(req_addr) < NUM_REGS) begin
                        // Bus address/data only change for decodable requests,
                        // so a decode error leaves the bus completely untouched.
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        state_d = ST_SETUP;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + CW'(1);
                // Ack takes priority over a timeout expiring in the same cycle
                if (bus_ack) begin
                    rdata_d = write_q ? '0 : bus_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and captured-request registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode from registers only; req_ready is additionally held low
    // while reset is asserted.
    assign req_ready = (state_q == ST_IDLE) && rst;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign bus_sel   = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign bus_wr_en = (state_q == ST_ACCESS) &&  write_q;
    assign bus_rd_en = (state_q == ST_ACCESS) && !write_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Randomized bench for reg_bus_initiator with a register-slave model on the
// bus and a reference register file predicting every response.
module tb_reg_bus_initiator;
    import reg_bus_pkg::*;

    localparam int NREG = 8;
    localparam int TMO  = 16;

    logic       clk, rst;
    logic       req_valid, req_ready, req_write;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_rdata;
    logic       bus_sel, bus_wr_en, bus_rd_en, bus_ack;
    logic [3:0] bus_addr;
    logic [7:0] bus_wdata, bus_rdata;

    reg_bus_initiator #(.AW(4), .DW(8), .NUM_REGS(NREG), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_sel(bus_sel), .bus_wr_en(bus_wr_en), .bus_rd_en(bus_rd_en),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    // plan_delay = ACCESS cycle (1-based) on which the slave acks; 0 = never.
    logic [7:0] slave_mem [16];
    int         plan_delay = 0;
    int         acc_cnt;
    logic       spur;
    logic       strobe, real_ack;

    assign strobe    = bus_wr_en | bus_rd_en;
    assign real_ack  = (plan_delay != 0) && (acc_cnt == plan_delay - 1);
    // Random acks outside ACCESS must be ignored by the master
    assign bus_ack   = strobe ? real_ack : spur;
    assign bus_rdata = slave_mem[bus_addr];

    always @(negedge clk) spur <= 1'($urandom_range(0, 1));

    always @(posedge clk or negedge rst) begin
        if (!rst) acc_cnt <= 0;
        else if (strobe) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always @(posedge clk) begin
        if (bus_wr_en && bus_ack) slave_mem[bus_addr] <= bus_wdata;
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [16];
    int         acc_wait;
    reg_bus_req_t nxt;

    // One transaction. Called and returns at a negedge.
    // dly: ACCESS cycle of the ack (0 = never), hold: cycles of rsp_ready=0,
    // chain: present request 'nxt' while the response is being held.
    task automatic do_txn(input logic wr, input logic [3:0] addr, input logic [7:0] wd,
                          input int dly, input int hold, input bit chain);
        bit         dec_err;
        bit         tmo;
        int         acc, exp_lat, cyc, sel_cnt, strb, bad, unstable;
        logic       exp_err;
        logic [7:0] exp_rd, got_rd;
        logic       got_err;

        dec_err = (addr >= NREG);
        tmo     = !dec_err && (dly == 0 || dly > TMO);
        acc     = dec_err ? 0 : (tmo ? TMO : dly);
        exp_lat = dec_err ? 1 : acc + 2;
        exp_err = dec_err || tmo;
        exp_rd  = (exp_err || wr) ? 8'h00 : ref_mem[addr];
        if (!exp_err && wr) ref_mem[addr] = wd;

        plan_delay = dly;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        acc_wait   = 0;
        while (!req_ready && acc_wait < 50) begin
            @(negedge clk);
            acc_wait++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;

        cyc = 1; sel_cnt = 0; strb = 0; bad = 0;
        while (!rsp_valid && cyc < 100) begin
            if (bus_sel) sel_cnt++;
            if (strobe) begin
                strb++;
                if (bus_wr_en !== wr || bus_rd_en !== !wr) bad++;
            end
            if (bus_sel && (bus_addr !== addr || bus_wdata !== wd)) bad++;
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, exp_lat);
        if (!rsp_valid) return;
        chk("sel_cycles", sel_cnt, dec_err ? 0 : acc + 1);
        chk("strobe_cycles", strb, acc);
        chk("bus_fields", bad, 0);
        got_err = rsp_err;
        got_rd  = rsp_rdata;
        chk("rsp_err", {31'd0, got_err}, {31'd0, exp_err});
        chk("rsp_rdata", {24'd0, got_rd}, {24'd0, exp_rd});

        rsp_ready = 1'b0;
        if (chain) begin
            req_write = nxt.write;
            req_addr  = nxt.addr;
            req_wdata = nxt.wdata;
            req_valid = 1'b1;
        end
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_err !== got_err || rsp_rdata !== got_rd ||
                req_ready !== 1'b0 || bus_sel !== 1'b0) unstable++;
        end
        if (hold > 0) chk("rsp_hold", unstable, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("back_to_idle", {30'd0, rsp_valid, req_ready}, 32'b01);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dtab [8] = '{1, 1, 2, 3, 5, 15, 16, 0};
        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        nxt = '0;
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = 8'($urandom);
            ref_mem[i]   = slave_mem[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_outputs", {27'd0, rsp_valid, rsp_err, bus_sel, bus_wr_en, bus_rd_en}, 32'd0);
        chk("rst_data", {12'd0, rsp_rdata, bus_addr, bus_wdata}, 32'd0);
        rst = 1'b1;
        #1;
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
        @(negedge clk);

        // directed cases
        do_txn(1'b1, 4'd2, 8'h05, 1, 0, 1'b0);   // write, ack first ACCESS cycle
        do_txn(1'b0, 4'd2, 8'h00, 3, 0, 1'b0);   // read back after 3 ACCESS cycles
        do_txn(1'b0, 4'd9, 8'h00, 1, 0, 1'b0);   // decode error
        do_txn(1'b1, 4'd5, 8'hA7, 0, 0, 1'b0);   // timeout, write not applied
        do_txn(1'b0, 4'd5, 8'h00, 1, 0, 1'b0);
        do_txn(1'b1, 4'd6, 8'h3C, 16, 0, 1'b0);  // ack on the last allowed cycle
        do_txn(1'b0, 4'd6, 8'h00, 2, 0, 1'b0);

        // held response with the next request already waiting
        nxt.write = 1'b0; nxt.addr = 4'd6; nxt.wdata = 8'h00;
        do_txn(1'b1, 4'd4, 8'h81, 2, 5, 1'b1);
        do_txn(nxt.write, nxt.addr, nxt.wdata, 1, 0, 1'b0);
        chk("b2b_accept_wait", acc_wait, 0);

        // reset in the middle of ACCESS
        plan_delay = 0;
        req_write = 1'b1; req_addr = 4'd3; req_wdata = 8'hEE; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_wr_en", {31'd0, bus_wr_en}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_outputs", {28'd0, bus_sel, bus_wr_en, rsp_valid, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_txn(1'b1, 4'd3, 8'h5A, 2, 1, 1'b0);
        do_txn(1'b0, 4'd3, 8'h00, 1, 0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            do_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)), 8'($urandom),
                   dtab[$urandom_range(0, 7)], $urandom_range(0, 3), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
